// File: rtl/banked_regfile.sv
// ----------------------------------------------------------------------------
// banked_regfile
//
// Multi-context integer register file. NUM_BANKS banks of 2**ADDR_W registers,
// one bank per task context. All NUM_RD read ports look at the bank selected
// by bank_sel_i; the single write port (writeback) may target any bank.
// A background clear engine zeroes one bank, one register per cycle, when a
// task slot is recycled. Register 0 of every bank always reads as zero.
//
// Optional feature (compile-time macro):
//   REGFILE_BYPASS_EN  - forward the same-cycle writeback data to a matching
//                        read port. Undefined: a write becomes visible in the
//                        cycle after the clock edge that performs it.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous reset, active high (aborts a running clear)
//   bank_sel_i   bank used by all read ports
//   re_i         per-port read enable
//   raddr_i      packed read addresses, port p at [p*ADDR_W +: ADDR_W]
//   rdata_o      packed read data (combinational), port p at [p*DATA_W +: DATA_W]
//   we_i         writeback write enable
//   wbank_i      writeback bank
//   waddr_i      writeback register index
//   wdata_i      writeback data
//   clr_req_i    start clearing bank clr_bank_i (pulse or level, IDLE only)
//   clr_bank_i   bank to clear
//   clr_busy_o   clear engine is zeroing registers
//   clr_done_o   one-cycle pulse after the last register was zeroed
// ----------------------------------------------------------------------------
module banked_regfile #(
    parameter  int DATA_W    = 32,
    parameter  int ADDR_W    = 5,
    parameter  int NUM_BANKS = 4,
    parameter  int NUM_RD    = 2,
    localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [BANK_W-1:0]        bank_sel_i,
    input  logic [NUM_RD-1:0]        re_i,
    input  logic [NUM_RD*ADDR_W-1:0] raddr_i,
    output logic [NUM_RD*DATA_W-1:0] rdata_o,
    input  logic                     we_i,
    input  logic [BANK_W-1:0]        wbank_i,
    input  logic [ADDR_W-1:0]        waddr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic                     clr_req_i,
    input  logic [BANK_W-1:0]        clr_bank_i,
    output logic                     clr_busy_o,
    output logic                     clr_done_o
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        CLR_IDLE,
        CLR_CLEAR,
        CLR_DONE
    } clr_state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    clr_state_e        clr_state_q;
    logic              clr_busy_q;
    logic              clr_done_q;
    logic [BANK_W-1:0] clr_bank_q;
    logic [ADDR_W-1:0] clr_idx_q;

    // Storage starts at zero in simulation so that an unwritten register has
    // a defined value; hardware makes no such promise.
    logic [DATA_W-1:0] regs_q [NUM_BANKS][NUM_REGS] = '{default: '0};

    // Bank indices can exceed NUM_BANKS when NUM_BANKS is not a power of two.
    // Zero-extending before the compare keeps it well defined for any width.
    function automatic logic bank_valid(input logic [BANK_W-1:0] bank);
        return 32'(bank) < 32'(NUM_BANKS);
    endfunction

    // ------------------------------------------------------------------
    // Write qualification
    // ------------------------------------------------------------------
    logic wb_blocked;
    logic wb_en;
    logic clr_wr_en;

    // The bank under clear is owned by the clear engine; writeback to it is
    // dropped so the two write sources can never collide.
    assign wb_blocked = clr_busy_q && (wbank_i == clr_bank_q);
    assign wb_en      = we_i && !rst_i && (waddr_i != '0)
                        && bank_valid(wbank_i) && !wb_blocked;

    // Reset also suppresses the clear write of the aborting cycle, so the
    // register at the current index keeps its old contents.
    assign clr_wr_en  = (clr_state_q == CLR_CLEAR) && !rst_i;

    // ------------------------------------------------------------------
    // Register storage
    // ------------------------------------------------------------------
    // NOTE: the register array has no reset branch on purpose; resetting a
    // memory turns it into a huge flop bank with a reset net on every bit.
    always_ff @(posedge clk_i) begin
        if (wb_en) begin
            regs_q[wbank_i][waddr_i] <= wdata_i;
        end
        if (clr_wr_en) begin
            regs_q[clr_bank_q][clr_idx_q] <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Clear engine
    // ------------------------------------------------------------------
    // Index 0 is skipped: register 0 is hardwired to read zero. The engine
    // therefore spends NUM_REGS-1 cycles in CLEAR and stops on the all-ones
    // index instead of wrapping.
    // NOTE: every state register here uses <= so all of them update from
    // the same pre-edge values; a blocking = would leak new values into
    // later statements of the same block.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clr_state_q <= CLR_IDLE;
            clr_busy_q  <= 1'b0;
            clr_done_q  <= 1'b0;
            clr_bank_q  <= '0;
            clr_idx_q   <= '0;
        end else begin
            case (clr_state_q)
                CLR_IDLE: begin
                    clr_done_q <= 1'b0;
                    if (clr_req_i && bank_valid(clr_bank_i)) begin
                        clr_state_q <= CLR_CLEAR;
                        clr_bank_q  <= clr_bank_i;
                        clr_idx_q   <= ADDR_W'(1);
                        clr_busy_q  <= 1'b1;
                    end
                end
                CLR_CLEAR: begin
                    if (clr_idx_q == '1) begin
                        clr_state_q <= CLR_DONE;
                        clr_busy_q  <= 1'b0;
                        clr_done_q  <= 1'b1;
                        clr_idx_q   <= '0;
                    end else begin
                        clr_idx_q   <= clr_idx_q + ADDR_W'(1);
                    end
                end
                CLR_DONE: begin
                    // Requests arriving here are dropped, not queued.
                    clr_state_q <= CLR_IDLE;
                    clr_done_q  <= 1'b0;
                end
                default: begin
                    clr_state_q <= CLR_IDLE;
                    clr_busy_q  <= 1'b0;
                    clr_done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign clr_busy_o = clr_busy_q;
    assign clr_done_o = clr_done_q;

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] raddr [NUM_RD];

    for (genvar gp = 0; gp < NUM_RD; gp++) begin : g_raddr
        assign raddr[gp] = raddr_i[gp*ADDR_W +: ADDR_W];
    end

    logic sel_clearing;
    logic sel_valid;

    // A bank being cleared is only partially zeroed; reading it as all-zero
    // hides the intermediate state from the task that will reuse it.
    assign sel_clearing = clr_busy_q && (bank_sel_i == clr_bank_q);
    assign sel_valid    = bank_valid(bank_sel_i);

    logic [NUM_RD*DATA_W-1:0] rdata_comb;

    // NOTE: rdata_comb gets its default before the loop so every path
    // assigns every bit; a missed branch would otherwise infer a latch.
    always_comb begin
        rdata_comb = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            if ((raddr[p] == '0) || !re_i[p]) begin
                rdata_comb[p*DATA_W +: DATA_W] = '0;
            end else if (sel_clearing || !sel_valid) begin
                rdata_comb[p*DATA_W +: DATA_W] = '0;
`ifdef REGFILE_BYPASS_EN
            end else if (wb_en && (wbank_i == bank_sel_i) && (waddr_i == raddr[p])) begin
                rdata_comb[p*DATA_W +: DATA_W] = wdata_i;
`endif
            end else begin
                rdata_comb[p*DATA_W +: DATA_W] = regs_q[bank_sel_i][raddr[p]];
            end
        end
    end

    assign rdata_o = rdata_comb;

endmodule

// File: tb/tb_banked_regfile.sv
// ----------------------------------------------------------------------------
// tb_banked_regfile
//
// Scoreboard bench for banked_regfile. A driver applies directed and random
// stimulus one cycle at a time; for every cycle it predicts the outputs from
// a plain array model of the register file and pushes them into a queue.
// A monitor on the falling edge pops each prediction and compares it with
// the DUT outputs. Build with +define+REGFILE_BYPASS_EN to check forwarding.
// ----------------------------------------------------------------------------
module tb_banked_regfile;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NB  = 4;
    localparam int NRD = 2;
    localparam int BW  = 2;
    localparam int NR  = 2 ** AW;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic                  rst_i;
    logic [BW-1:0]         bank_sel_i;
    logic [NRD-1:0]        re_i;
    logic [NRD*AW-1:0]     raddr_i;
    logic [NRD*DW-1:0]     rdata_o;
    logic                  we_i;
    logic [BW-1:0]         wbank_i;
    logic [AW-1:0]         waddr_i;
    logic [DW-1:0]         wdata_i;
    logic                  clr_req_i;
    logic [BW-1:0]         clr_bank_i;
    logic                  clr_busy_o;
    logic                  clr_done_o;

    banked_regfile #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .NUM_BANKS (NB),
        .NUM_RD    (NRD)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .bank_sel_i (bank_sel_i),
        .re_i       (re_i),
        .raddr_i    (raddr_i),
        .rdata_o    (rdata_o),
        .we_i       (we_i),
        .wbank_i    (wbank_i),
        .waddr_i    (waddr_i),
        .wdata_i    (wdata_i),
        .clr_req_i  (clr_req_i),
        .clr_bank_i (clr_bank_i),
        .clr_busy_o (clr_busy_o),
        .clr_done_o (clr_done_o)
    );

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int    checks   = 0;
    int    failures = 0;
    string phase    = "init";

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: contents per bank, plus the clear job in flight
    // ------------------------------------------------------------------
    logic [DW-1:0] m_mem [NB][NR];
    bit            m_busy;
    bit            m_done;
    int            m_cbank;
    int            m_cidx;   // next register the clear job will zero

    function automatic bit write_ok();
        return we_i && !rst_i && (waddr_i != 0) && (int'(wbank_i) < NB)
               && !(m_busy && int'(wbank_i) == m_cbank);
    endfunction

    function automatic logic [DW-1:0] model_read(input int p);
        int a;
        a = int'(raddr_i[p*AW +: AW]);
        if (a == 0 || !re_i[p]) return '0;
        if (m_busy && int'(bank_sel_i) == m_cbank) return '0;
        if (int'(bank_sel_i) >= NB) return '0;
`ifdef REGFILE_BYPASS_EN
        if (write_ok() && wbank_i == bank_sel_i && int'(waddr_i) == a) return wdata_i;
`endif
        return m_mem[bank_sel_i][a];
    endfunction

    // Apply one clock edge worth of effects to the model.
    task automatic model_edge();
        if (rst_i) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            return;
        end
        if (write_ok()) m_mem[wbank_i][waddr_i] = wdata_i;
        if (m_busy) begin
            m_mem[m_cbank][m_cidx] = '0;
            if (m_cidx == NR - 1) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end else begin
                m_cidx++;
            end
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (clr_req_i && int'(clr_bank_i) < NB) begin
            m_busy  = 1'b1;
            m_cbank = int'(clr_bank_i);
            m_cidx  = 1;
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [NRD*DW-1:0] rd;
        logic              busy;
        logic              done;
    } exp_t;

    exp_t exp_q [$];
    exp_t mon_e;

    always @(negedge clk_i) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            for (int p = 0; p < NRD; p++) begin
                check($sformatf("%s rdata%0d", phase, p),
                      rdata_o[p*DW +: DW], mon_e.rd[p*DW +: DW]);
            end
            check({phase, " clr_busy"}, 32'(clr_busy_o), 32'(mon_e.busy));
            check({phase, " clr_done"}, 32'(clr_done_o), 32'(mon_e.done));
        end
    end

    // One cycle: predict outputs for the inputs now applied, let the edge
    // happen, advance the model, then move off the edge.
    task automatic step();
        exp_t e;
        for (int p = 0; p < NRD; p++) e.rd[p*DW +: DW] = model_read(p);
        e.busy = m_busy;
        e.done = m_done;
        exp_q.push_back(e);
        @(posedge clk_i);
        model_edge();
        #1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic idle();
        rst_i      = 1'b0;
        we_i       = 1'b0;
        wbank_i    = '0;
        waddr_i    = '0;
        wdata_i    = '0;
        re_i       = '0;
        raddr_i    = '0;
        bank_sel_i = '0;
        clr_req_i  = 1'b0;
        clr_bank_i = '0;
    endtask

    task automatic wr(input int b, input int a, input logic [DW-1:0] d);
        we_i    = 1'b1;
        wbank_i = BW'(b);
        waddr_i = AW'(a);
        wdata_i = d;
        step();
        we_i    = 1'b0;
    endtask

    task automatic rd2(input int sel, input int a0, input int a1);
        re_i       = 2'b11;
        bank_sel_i = BW'(sel);
        raddr_i    = {AW'(a1), AW'(a0)};
        step();
        re_i       = '0;
    endtask

    task automatic dump_bank(input int b);
        for (int r = 0; r < NR; r++) rd2(b, r, NR - 1 - r);
    endtask

    // Runs n cycles, counting busy and done as seen just after each edge.
    task automatic watch(input int n, output int busy_cnt, output int done_cnt);
        busy_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < n; c++) begin
            if (clr_busy_o) busy_cnt++;
            if (clr_done_o) done_cnt++;
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    initial begin
        int busy_cnt;
        int done_cnt;

        for (int b = 0; b < NB; b++)
            for (int r = 0; r < NR; r++) m_mem[b][r] = '0;
        m_busy  = 1'b0;
        m_done  = 1'b0;
        m_cbank = 0;
        m_cidx  = 0;

        idle();
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        phase = "reset";
        check("reset clr_busy", 32'(clr_busy_o), 32'd0);
        check("reset clr_done", 32'(clr_done_o), 32'd0);
        rd2(0, 1, 31);
        rd2(3, 17, 4);

        // T1: write lands in its bank only
        phase = "T1";
        wr(1, 5, 32'hDEADBEEF);
        rd2(1, 5, 5);
        rd2(0, 5, 5);

        // T2: register 0 stays zero, disabled ports read zero
        phase = "T2";
        for (int b = 0; b < NB; b++) wr(b, 0, 32'h1234);
        for (int b = 0; b < NB; b++) rd2(b, 0, 0);
        re_i       = 2'b00;
        bank_sel_i = 2'd1;
        raddr_i    = {AW'(5), AW'(5)};
        step();
        re_i       = 2'b01;
        step();
        re_i       = '0;

        // T3: same-cycle write and read of the same register
        phase = "T3";
        wr(2, 7, 32'h11111111);
        we_i       = 1'b1;
        wbank_i    = 2'd2;
        waddr_i    = 5'd7;
        wdata_i    = 32'hA5A5A5A5;
        rd2(2, 7, 7);
        we_i       = 1'b0;
        rd2(2, 7, 7);

        // T4: clear bank 3 while other banks hold data
        phase = "T4";
        for (int r = 1; r < NR; r++) wr(3, r, $urandom | 32'h1);
        for (int b = 0; b < 3; b++)
            for (int r = 1; r < NR; r += 3) wr(b, r, $urandom);
        clr_req_i  = 1'b1;
        clr_bank_i = 2'd3;
        step();
        clr_req_i  = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (clr_busy_o) busy_cnt++;
            if (clr_done_o) done_cnt++;
            if (c == 5) begin
                we_i = 1'b1; wbank_i = 2'd3; waddr_i = 5'd9; wdata_i = 32'hCAFEF00D;
                re_i = 2'b11; bank_sel_i = 2'd3; raddr_i = {AW'(9), AW'(30)};
            end else if (c == 6) begin
                we_i = 1'b1; wbank_i = 2'd0; waddr_i = 5'd2; wdata_i = 32'h0F0F0F0F;
                re_i = 2'b11; bank_sel_i = 2'd0; raddr_i = {AW'(2), AW'(1)};
            end else begin
                we_i = 1'b0; re_i = '0;
            end
            step();
        end
        check("T4 busy cycles", busy_cnt, 31);
        check("T4 done pulses", done_cnt, 1);
        for (int b = 0; b < NB; b++) dump_bank(b);

        // T5: extra requests during CLEAR and DONE are ignored
        phase = "T5";
        clr_req_i  = 1'b1;
        clr_bank_i = 2'd2;
        step();
        busy_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (clr_busy_o) busy_cnt++;
            if (clr_done_o) done_cnt++;
            clr_req_i  = (c == 3 || c == 10 || c == 31);
            clr_bank_i = 2'd0;
            step();
        end
        clr_req_i = 1'b0;
        check("T5 busy cycles", busy_cnt, 31);
        check("T5 done pulses", done_cnt, 1);
        dump_bank(0);

        // T6: reset aborts a clear at index 10
        phase = "T6";
        for (int r = 1; r < NR; r++) wr(1, r, 32'h5A000000 | 32'(r));
        clr_req_i  = 1'b1;
        clr_bank_i = 2'd1;
        step();
        clr_req_i  = 1'b0;
        repeat (9) step();
        rst_i   = 1'b1;
        we_i    = 1'b1;
        wbank_i = 2'd0;
        waddr_i = 5'd3;
        wdata_i = 32'h0BADF00D;
        step();
        idle();
        check("T6 busy after reset", 32'(clr_busy_o), 32'd0);
        check("T6 done after reset", 32'(clr_done_o), 32'd0);
        watch(35, busy_cnt, done_cnt);
        check("T6 busy cycles after abort", busy_cnt, 0);
        check("T6 done pulses after abort", done_cnt, 0);
        dump_bank(1);
        rd2(0, 3, 2);

        // Random traffic
        phase = "rand";
        for (int n = 0; n < 900; n++) begin
            rst_i      = ($urandom_range(0, 99) == 0);
            we_i       = 1'($urandom_range(0, 1));
            wbank_i    = BW'($urandom_range(0, NB - 1));
            waddr_i    = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
            wdata_i    = $urandom;
            bank_sel_i = ($urandom_range(0, 3) == 0) ? wbank_i : BW'($urandom_range(0, NB - 1));
            re_i       = NRD'($urandom);
            raddr_i    = NRD*AW'($urandom);
            if ($urandom_range(0, 3) == 0) raddr_i[0 +: AW] = waddr_i;
            if ($urandom_range(0, 3) == 0) raddr_i[AW +: AW] = waddr_i;
            clr_req_i  = ($urandom_range(0, 29) == 0);
            clr_bank_i = BW'($urandom_range(0, NB - 1));
            step();
        end
        idle();
        phase = "final";
        for (int b = 0; b < NB; b++) dump_bank(b);

        repeat (2) @(negedge clk_i);
        check("scoreboard drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
